// File: rtl/sparce_sasa_loader.sv
// Bulk-configuration sequencer for the SPARCE SASA table: shares the table write port
// between direct CPU stores and a memory-fed block loader.
module sparce_sasa_loader #(
    parameter logic [31:0] SASA_ADDR   = 32'h9000_0000,
    parameter int unsigned MAX_ENTRIES = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        cpu_wen,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_stall,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        sasa_enable,
    output logic        sasa_wen,
    output logic [31:0] sasa_addr,
    output logic [31:0] sasa_data,
    output logic [31:0] status,
    output logic        done_pulse
);

    localparam int unsigned CNT_W = 5;

    typedef enum logic [1:0] {IDLE, FETCH, WRITE, DONE} state_t;

    state_t             state;
    logic [31:0]        base;
    logic [31:0]        ptr;
    logic [31:0]        data_q;
    logic [CNT_W-1:0]   remaining;
    logic               aborted;
    logic               overrun;
    logic               abort_pend;

    logic               hit_tbl;
    logic               hit_base;
    logic               hit_ctrl;
    logic               start_req;
    logic               abort_req;
    logic               abort_now;
    logic               busy;
    logic [CNT_W-1:0]   cnt_in;
    logic [CNT_W-1:0]   cnt_clamp;

    // Store decode and load-control terms
    always_comb begin
        hit_tbl   = cpu_wen && ((cpu_addr == SASA_ADDR) || (cpu_addr == SASA_ADDR + 32'd4));
        hit_base  = cpu_wen && (cpu_addr == SASA_ADDR + 32'd8);
        hit_ctrl  = cpu_wen && (cpu_addr == SASA_ADDR + 32'd12);
        start_req = hit_ctrl && cpu_wdata[8];
        abort_req = hit_ctrl && cpu_wdata[9];
        busy      = (state != IDLE);
        abort_now = abort_pend || abort_req;
        cnt_in    = cpu_wdata[CNT_W-1:0];
        cnt_clamp = (cnt_in > CNT_W'(MAX_ENTRIES)) ? CNT_W'(MAX_ENTRIES) : cnt_in;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            base       <= '0;
            ptr        <= '0;
            data_q     <= '0;
            remaining  <= '0;
            aborted    <= 1'b0;
            overrun    <= 1'b0;
            abort_pend <= 1'b0;
        end else begin
            if (hit_base) base <= {cpu_wdata[31:2], 2'b00};
            if (busy && start_req) overrun <= 1'b1;
            if (busy && abort_req) abort_pend <= 1'b1;

            case (state)
                IDLE: begin
                    abort_pend <= 1'b0;
                    if (start_req) begin
                        remaining <= cnt_clamp;
                        ptr       <= base;
                        aborted   <= 1'b0;
                        overrun   <= 1'b0;
                        state     <= (cnt_in == '0) ? DONE : FETCH;
                    end
                end
                FETCH: begin
                    // The beat always completes; an abort only drops its data
                    if (mem_ready) begin
                        data_q <= mem_rdata;
                        ptr    <= ptr + 32'd4;
                        if (abort_now) begin
                            aborted <= 1'b1;
                            state   <= DONE;
                        end else begin
                            state   <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    remaining <= remaining - CNT_W'(1);
                    if (abort_now) aborted <= 1'b1;
                    state <= ((remaining == CNT_W'(1)) || abort_now) ? DONE : FETCH;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Table port: CPU pass-through in IDLE, loader beat in WRITE
    always_comb begin
        sasa_enable = 1'b0;
        sasa_wen    = 1'b0;
        sasa_addr   = '0;
        sasa_data   = '0;
        case (state)
            IDLE: begin
                if (hit_tbl) begin
                    sasa_enable = 1'b1;
                    sasa_wen    = 1'b1;
                    sasa_addr   = cpu_addr;
                    sasa_data   = cpu_wdata;
                end
            end
            WRITE: begin
                sasa_enable = 1'b1;
                sasa_wen    = 1'b1;
                sasa_addr   = SASA_ADDR;
                sasa_data   = data_q;
            end
            default: ;
        endcase
    end

    assign mem_req    = (state == FETCH);
    assign mem_addr   = (state == FETCH) ? ptr : 32'd0;
    assign cpu_stall  = hit_tbl && busy;
    assign done_pulse = (state == DONE);
    assign status     = {busy, aborted, overrun, 24'd0, remaining};

endmodule
